// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_pkg;

  // Counter width that can hold values up to n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for one asynchronous level, with synchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) chain_q <= '0;
    else       chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button.sv
// Debounced push-button: synchronise, accept a level after DEBOUNCE_TIME stable
// cycles, and emit one registered single-cycle pulse per accepted press.
module button
  import button_pkg::*;
#(
  parameter int DEBOUNCE_TIME = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic one_shot_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_TIME);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TIME - 1);

  logic             sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (sync_q)
  );

  // Counter runs only while the synchronised level disagrees with the accepted
  // one; any agreement restarts it, so it can never pass CNT_MAX.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync_q;
        pulse_d  = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign one_shot_pulse = pulse_q;

endmodule

// File: tb/tb_button.sv
// Randomised bench for the button debouncer against a sliding-window reference model.
module tb_button;

  localparam int D = 1000;
  localparam int S = 2;

  logic clk;
  logic reset;
  logic button_in;
  logic one_shot_pulse;

  int tests_run = 0;
  int tests_failed = 0;
  int pulse_count = 0;

  button #(.DEBOUNCE_TIME(D), .SYNC_STAGES(S)) dut (
    .clk            (clk),
    .reset          (reset),
    .button_in      (button_in),
    .one_shot_pulse (one_shot_pulse)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the accepted level flips when the last D synchronised
  // samples (none older than the last flip or reset) all differ from it.
  logic pipe_q[$];
  logic window_q[$];
  logic m_stable;
  logic m_pulse;

  always @(posedge clk) begin
    logic cur;
    int   n_diff;
    if (reset) begin
      pipe_q   = {};
      for (int i = 0; i < S; i++) pipe_q.push_back(1'b0);
      window_q = {};
      m_stable = 1'b0;
      m_pulse  = 1'b0;
    end else begin
      cur = pipe_q[S-1];
      window_q.push_back(cur);
      if (window_q.size() > D) void'(window_q.pop_front());
      m_pulse = 1'b0;
      n_diff = 0;
      foreach (window_q[i]) if (window_q[i] != m_stable) n_diff++;
      if (n_diff == D) begin
        m_stable = cur;
        m_pulse  = cur;
        window_q = {};
      end
      pipe_q.push_front(button_in);
      void'(pipe_q.pop_back());
    end
    #1;
    if (one_shot_pulse) pulse_count++;
    if (one_shot_pulse !== m_pulse) check_eq("pulse", 32'(one_shot_pulse), 32'(m_pulse));
    if (dut.stable_q !== m_stable) check_eq("stable", 32'(dut.stable_q), 32'(m_stable));
  end

  // driver tasks
  task automatic hold(input logic lvl, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      button_in = lvl;
    end
  endtask

  // Drives a press at the next negedge and returns the edge index of the first pulse.
  task automatic press_latency(output int edge_n);
    edge_n = -1;
    @(negedge clk);
    button_in = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #2;
      if (one_shot_pulse) begin
        edge_n = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    int wide;
    reset = 1'b1;
    button_in = 1'b0;

    // Reset held with button toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      button_in = 1'($urandom_range(0, 1));
      check_eq("reset_pulse", 32'(one_shot_pulse), 32'd0);
      check_eq("reset_stable", 32'(dut.stable_q), 32'd0);
    end
    @(negedge clk);
    button_in = 1'b0;
    reset = 1'b0;

    // Bounce rejection.
    base = pulse_count;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 20);
    check_eq("bounce_pulses", 32'(pulse_count - base), 32'd0);
    check_eq("bounce_stable", 32'(dut.stable_q), 32'd0);

    // Long press: latency and single pulse.
    base = pulse_count;
    press_latency(lat);
    check_eq("press_latency", 32'(lat), 32'(S + D));
    @(posedge clk);
    #2;
    check_eq("pulse_width", 32'(one_shot_pulse), 32'd0);
    hold(1'b1, 5000 - lat - 1);
    check_eq("long_press_pulses", 32'(pulse_count - base), 32'd1);
    check_eq("long_press_stable", 32'(dut.stable_q), 32'd1);

    // Release then re-press.
    base = pulse_count;
    hold(1'b0, S + D + 10);
    check_eq("release_stable", 32'(dut.stable_q), 32'd0);
    check_eq("release_pulses", 32'(pulse_count - base), 32'd0);
    hold(1'b1, S + D + 10);
    check_eq("repress_pulses", 32'(pulse_count - base), 32'd1);

    // Near miss (D-1) then exact D.
    hold(1'b0, S + D + 10);
    base = pulse_count;
    hold(1'b1, D - 1);
    hold(1'b0, S + D + 10);
    check_eq("near_miss_pulses", 32'(pulse_count - base), 32'd0);
    check_eq("near_miss_stable", 32'(dut.stable_q), 32'd0);
    hold(1'b1, D);
    hold(1'b0, S + 5);
    check_eq("exact_d_pulses", 32'(pulse_count - base), 32'd1);
    hold(1'b0, S + D + 10);

    // Reset mid-debounce while still pressed.
    base = pulse_count;
    hold(1'b1, S + 500);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wide = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk);
      #2;
      if (one_shot_pulse) begin
        wide = n;
        break;
      end
    end
    check_eq("reset_mid_latency", 32'(wide), 32'(S + D));
    check_eq("reset_mid_pulses", 32'(pulse_count - base), 32'd1);
    hold(1'b0, S + D + 10);

    // Random segments mixing short glitches and long holds.
    for (int seg = 0; seg < 24; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) len = $urandom_range(D - 5, D + 200);
      else                           len = $urandom_range(1, 40);
      hold(lvl, len);
    end
    hold(1'b0, S + D + 10);
    check_eq("random_final_stable", 32'(dut.stable_q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
